// File: rtl/decode_imm_stage_pkg.sv
// Shared definitions for the decode/immediate stage: opcode constants,
// immediate-format codes, occupancy states, the decoded-entry record and
// the immediate_unit extraction function.
package decode_imm_stage_pkg;

    localparam int XLEN_P = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // UNKNOWN is code 0 so a reset entry reads as "no immediate"
    typedef enum logic [2:0] {
        IMM_UNKNOWN_TYPE = 3'd0,
        IMM_I            = 3'd1,
        IMM_S            = 3'd2,
        IMM_B            = 3'd3,
        IMM_U            = 3'd4,
        IMM_J            = 3'd5
    } imm_sel_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN_P-1:0] imm;
        imm_sel_e          sel;
        logic [XLEN_P-1:0] pc;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [2:0]        funct3;
        logic              illegal;
    } dec_entry_t;

    // Immediate unit: sign-extended immediate for the selected format,
    // forced to 0 when disabled or when the format carries no immediate.
    function automatic logic [XLEN_P-1:0] immediate_unit(
        input logic [XLEN_P-1:0] instr,
        input imm_sel_e          sel,
        input logic              enable
    );
        logic [XLEN_P-1:0] imm;
        imm = '0;
        if (enable) begin
            case (sel)
                IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
                IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                instr[11:8], 1'b0};
                IMM_U:   imm = {instr[31:12], 12'b0};
                IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                instr[30:21], 1'b0};
                default: imm = '0;
            endcase
        end
        return imm;
    endfunction

endpackage

// File: rtl/decode_imm_stage_imm_type_decoder.sv
// imm_type_decoder: purely combinational opcode classifier producing the
// immediate-format code and the illegal-opcode flag.
module imm_type_decoder
    import decode_imm_stage_pkg::*;
(
    input  logic [6:0] opcode_i,
    output imm_sel_e   sel_o,
    output logic       illegal_o
);

    // Map each supported opcode to its format; R-type is legal but immediate-free
    always_comb begin
        sel_o     = IMM_UNKNOWN_TYPE;
        illegal_o = 1'b0;
        case (opcode_i)
            OPC_LUI, OPC_AUIPC:           sel_o = IMM_U;
            OPC_JAL:                      sel_o = IMM_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: sel_o = IMM_I;
            OPC_STORE:                    sel_o = IMM_S;
            OPC_BRANCH:                   sel_o = IMM_B;
            OPC_OP:                       sel_o = IMM_UNKNOWN_TYPE;
            default:                      illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_imm_stage.sv
// decode_imm_stage: accepts instructions from fetch over valid/ready, decodes
// the immediate format and register fields, and presents one registered entry
// to execute with backpressure and flush.
// Optional feature macro: DECODE_SKID_BUFFER_EN selects a two-entry skid buffer
// with a registered o_Instr_Ready; without it a single register is used and
// o_Instr_Ready is combinational from i_Dec_Ready.
module decode_imm_stage
    import decode_imm_stage_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int IMM_SEL_WIDTH = 2
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset_N,
    input  logic                   i_Flush,
    input  logic                   i_Instr_Valid,
    output logic                   o_Instr_Ready,
    input  logic [XLEN-1:0]        i_Instruction,
    input  logic [XLEN-1:0]        i_PC,
    output logic                   o_Dec_Valid,
    input  logic                   i_Dec_Ready,
    output logic [XLEN-1:0]        o_Immediate,
    output logic [IMM_SEL_WIDTH:0] o_Imm_Select,
    output logic [XLEN-1:0]        o_PC,
    output logic [4:0]             o_Rd,
    output logic [4:0]             o_Rs1,
    output logic [4:0]             o_Rs2,
    output logic [2:0]             o_Funct3,
    output logic                   o_Illegal
);

    logic [XLEN_P-1:0] instr;
    imm_sel_e          dec_sel;
    logic              dec_illegal;
    logic              instr_ready;
    logic              accept;
    logic              consume;
    logic              imm_enable;
    dec_entry_t        entry_d;
    dec_entry_t        main_q;
    state_e            state_q;

    assign instr = XLEN_P'(i_Instruction);

    imm_type_decoder u_imm_type_decoder (
        .opcode_i  (instr[6:0]),
        .sel_o     (dec_sel),
        .illegal_o (dec_illegal)
    );

    assign imm_enable = i_Instr_Valid & instr_ready;
    assign accept     = imm_enable & ~i_Flush;
    assign consume    = o_Dec_Valid & i_Dec_Ready;

    // Assemble the entry that would be captured if this cycle transfers
    always_comb begin
        entry_d         = '0;
        entry_d.imm     = immediate_unit(instr, dec_sel, imm_enable);
        entry_d.sel     = dec_sel;
        entry_d.pc      = XLEN_P'(i_PC);
        entry_d.rd      = instr[11:7];
        entry_d.rs1     = instr[19:15];
        entry_d.rs2     = instr[24:20];
        entry_d.funct3  = instr[14:12];
        entry_d.illegal = dec_illegal;
    end

`ifdef DECODE_SKID_BUFFER_EN
    dec_entry_t skid_q;
    logic       ready_q;

    assign instr_ready = ready_q;

    // Occupancy FSM: main_q feeds execute, skid_q catches the entry accepted
    // while execute stalls; ready is registered so it never depends on i_Dec_Ready
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (i_Flush) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
        end else begin
            ready_q <= 1'b1;
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q  <= entry_d;
                        state_q <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && !consume) begin
                        skid_q  <= entry_d;
                        state_q <= ST_TWO;
                        ready_q <= 1'b0;
                    end else if (accept && consume) begin
                        main_q  <= entry_d;
                    end else if (consume) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (consume) begin
                        main_q  <= skid_q;
                        state_q <= ST_ONE;
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end
`else
    assign instr_ready = ~o_Dec_Valid | i_Dec_Ready;

    // Single holding register: refill on accept (which implies any held entry
    // is leaving), otherwise drain on consume
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
        end else if (i_Flush) begin
            state_q <= ST_EMPTY;
        end else if (accept) begin
            main_q  <= entry_d;
            state_q <= ST_ONE;
        end else if (consume) begin
            state_q <= ST_EMPTY;
        end
    end
`endif

    assign o_Instr_Ready = instr_ready;
    assign o_Dec_Valid   = (state_q != ST_EMPTY);
    assign o_Immediate   = XLEN'(main_q.imm);
    assign o_Imm_Select  = (IMM_SEL_WIDTH + 1)'(main_q.sel);
    assign o_PC          = XLEN'(main_q.pc);
    assign o_Rd          = main_q.rd;
    assign o_Rs1         = main_q.rs1;
    assign o_Rs2         = main_q.rs2;
    assign o_Funct3      = main_q.funct3;
    assign o_Illegal     = main_q.illegal;

endmodule

// File: tb/tb_decode_imm_stage.sv
// Directed testbench for decode_imm_stage: reset, format decode, backpressure,
// flush, illegal/R-type opcodes and reset during a held entry.
module tb_decode_imm_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] imm;
    logic [2:0]  sel;
    logic [31:0] dpc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] SEL_UNK = 3'd0, SEL_I = 3'd1, SEL_S = 3'd2,
                           SEL_B = 3'd3, SEL_U = 3'd4, SEL_J = 3'd5;

    always #5 clk = ~clk;

    decode_imm_stage dut (
        .i_Clock       (clk),
        .i_Reset_N     (rst_n),
        .i_Flush       (flush),
        .i_Instr_Valid (in_valid),
        .o_Instr_Ready (in_ready),
        .i_Instruction (instr),
        .i_PC          (pc),
        .o_Dec_Valid   (dec_valid),
        .i_Dec_Ready   (dec_ready),
        .o_Immediate   (imm),
        .o_Imm_Select  (sel),
        .o_PC          (dpc),
        .o_Rd          (rd),
        .o_Rs1         (rs1),
        .o_Rs2         (rs2),
        .o_Funct3      (funct3),
        .o_Illegal     (illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b1; dec_ready = 1'b1;
        instr = 32'hFFF00093; pc = 32'h0000_0100;
        #1 rst_n = 1'b0;

        // 1. reset held three cycles with valid asserted
        step(); step(); step();
        check("rst_valid", {31'd0, dec_valid}, 32'd0);
        check("rst_imm", imm, 32'd0);
        check("rst_sel", {29'd0, sel}, 32'd0);
        check("rst_pc", dpc, 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        check("rst_ready", {31'd0, in_ready}, 32'd1);

        // 2. ADDI x1, x0, -1
        in_valid = 1'b1; instr = 32'hFFF00093; pc = 32'h0000_0100;
        step();
        in_valid = 1'b0;
        check("addi_valid", {31'd0, dec_valid}, 32'd1);
        check("addi_sel", {29'd0, sel}, {29'd0, SEL_I});
        check("addi_imm", imm, 32'hFFFF_FFFF);
        check("addi_rd", {27'd0, rd}, 32'd1);
        check("addi_pc", dpc, 32'h0000_0100);
        check("addi_ill", {31'd0, illegal}, 32'd0);

        // 3. BEQ with offset -4
        in_valid = 1'b1; instr = 32'hFE000EE3; pc = 32'h0000_0104;
        step();
        in_valid = 1'b0;
        check("beq_imm", imm, 32'hFFFF_FFFC);
        check("beq_sel", {29'd0, sel}, {29'd0, SEL_B});
        check("beq_ill", {31'd0, illegal}, 32'd0);
        check("beq_pc", dpc, 32'h0000_0104);
        step();
        check("drain_valid", {31'd0, dec_valid}, 32'd0);

        // 4. backpressure: LUI then SW while execute stalls
        dec_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h123450B7; pc = 32'h0000_0200;
        step();
        check("lui_valid", {31'd0, dec_valid}, 32'd1);
        check("lui_imm", imm, 32'h1234_5000);
        check("lui_sel", {29'd0, sel}, {29'd0, SEL_U});
        instr = 32'h00112223; pc = 32'h0000_0204;
`ifdef DECODE_SKID_BUFFER_EN
        check("sw_push_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("full_ready", {31'd0, in_ready}, 32'd0);
        check("full_hold_imm", imm, 32'h1234_5000);
        instr = 32'hFFF00093; pc = 32'h0000_0208;
        step();
        check("full_ready2", {31'd0, in_ready}, 32'd0);
        check("full_hold_pc", dpc, 32'h0000_0200);
        in_valid = 1'b0; dec_ready = 1'b1;
        step();
        check("sw_imm", imm, 32'h0000_0004);
        check("sw_sel", {29'd0, sel}, {29'd0, SEL_S});
        check("sw_pc", dpc, 32'h0000_0204);
        check("sw_valid", {31'd0, dec_valid}, 32'd1);
        step();
        check("after_sw_valid", {31'd0, dec_valid}, 32'd0);
`else
        check("stall_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("stall_hold_imm", imm, 32'h1234_5000);
        check("stall_hold_pc", dpc, 32'h0000_0200);
        dec_ready = 1'b1;
        #1;
        check("unstall_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("sw_imm", imm, 32'h0000_0004);
        check("sw_sel", {29'd0, sel}, {29'd0, SEL_S});
        check("sw_pc", dpc, 32'h0000_0204);
        step();
        check("after_sw_valid", {31'd0, dec_valid}, 32'd0);
`endif

        // 5. flush with one entry held and a same-cycle incoming instruction
        dec_ready = 1'b0;
        in_valid = 1'b1; instr = 32'hFFF00093; pc = 32'h0000_0300;
        step();
        check("pre_flush_valid", {31'd0, dec_valid}, 32'd1);
        flush = 1'b1; instr = 32'h123450B7; pc = 32'h0000_0304;
        step();
        flush = 1'b0; in_valid = 1'b0; dec_ready = 1'b1;
        check("flush_valid", {31'd0, dec_valid}, 32'd0);
        check("flush_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("flush_later1", {31'd0, dec_valid}, 32'd0);
        step();
        check("flush_later2", {31'd0, dec_valid}, 32'd0);

        // 6. illegal opcode, then R-type, then JAL back to back
        in_valid = 1'b1; instr = 32'h0000007F; pc = 32'h0000_0400;
        step();
        check("ill_valid", {31'd0, dec_valid}, 32'd1);
        check("ill_flag", {31'd0, illegal}, 32'd1);
        check("ill_imm", imm, 32'd0);
        check("ill_sel", {29'd0, sel}, {29'd0, SEL_UNK});
        instr = 32'h002081B3; pc = 32'h0000_0404;
        step();
        check("add_ill", {31'd0, illegal}, 32'd0);
        check("add_imm", imm, 32'd0);
        check("add_sel", {29'd0, sel}, {29'd0, SEL_UNK});
        check("add_regs", {17'd0, rd, rs1, rs2}, {17'd0, 5'd3, 5'd1, 5'd2});
        check("add_pc", dpc, 32'h0000_0404);
        instr = 32'h008000EF; pc = 32'h0000_0408;
        step();
        in_valid = 1'b0;
        check("jal_imm", imm, 32'h0000_0008);
        check("jal_sel", {29'd0, sel}, {29'd0, SEL_J});
        check("jal_rd", {27'd0, rd}, 32'd1);
        check("jal_f3", {29'd0, funct3}, 32'd0);

        // 7. reset asserted while an entry is held
        dec_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00112223; pc = 32'h0000_0500;
        step();
        check("pre_rst_valid", {31'd0, dec_valid}, 32'd1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, dec_valid}, 32'd0);
        check("async_rst_imm", imm, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_valid", {31'd0, dec_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
